fetch_stage: RTL

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/riscky_pkg.sv | 5 +
 rtl/fetch_stage.sv | 135 +++++++++++++
 2 files changed

// File: rtl/riscky_pkg.sv
// Shared core-wide widths for the riscky pipeline.
package riscky_pkg;
    localparam int XLEN = 64;
    localparam int ILEN = 32;
endpackage

// File: rtl/fetch_stage.sv
// Instruction fetch stage: one-outstanding-request fetch FSM feeding the IF/ID register.
//  state  | meaning
//  S_REQ  | imem_req_valid high, waiting for the handshake
//  S_WAIT | one request outstanding, waiting for its response
//  S_HOLD | response parked in the buffer while decode stalls
//  S_DROP | outstanding response belongs to a squashed path, discard it
module fetch_stage
    import riscky_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pc_src_e,
    input  logic [XLEN-1:0] pc_target_e,
    input  logic            stall_d,
    input  logic            flush_d,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [ILEN-1:0] imem_rsp_data,
    output logic [ILEN-1:0] instr_d,
    output logic [XLEN-1:0] pc_d,
    output logic [XLEN-1:0] pc_plus4_d,
    output logic            valid_d
);
    localparam logic [ILEN-1:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_DROP} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [XLEN-1:0] r_pc_f;
    logic [XLEN-1:0] w_pc_f_nxt;
    logic [XLEN-1:0] w_pc_plus4_f;
    logic [ILEN-1:0] r_buf;
    logic [ILEN-1:0] w_buf_nxt;
    logic            w_hs;
    logic            w_outstanding;
    logic            w_load;
    logic            w_hold;
    logic [ILEN-1:0] w_load_instr;
    logic [ILEN-1:0] r_instr_d;
    logic [XLEN-1:0] r_pc_d;
    logic [XLEN-1:0] r_pc_plus4_d;
    logic            r_valid_d;

    assign imem_req_valid = (r_state == S_REQ) && !rst;
    assign imem_req_addr  = r_pc_f;
    assign w_hs           = imem_req_valid && imem_req_ready;
    assign w_pc_plus4_f   = r_pc_f + XLEN'(4);
    assign w_outstanding  = (r_state == S_WAIT) || (r_state == S_DROP) ||
                            ((r_state == S_REQ) && w_hs);

    always_comb begin
        w_state_nxt  = r_state;
        w_pc_f_nxt   = r_pc_f;
        w_buf_nxt    = r_buf;
        w_load       = 1'b0;
        w_hold       = 1'b0;
        w_load_instr = imem_rsp_data;
        if (pc_src_e) begin
            w_pc_f_nxt  = pc_target_e;
            w_state_nxt = (w_outstanding && !imem_rsp_valid) ? S_DROP : S_REQ;
        end else if (flush_d) begin
            // A response accepted under flush is dropped; pc_f stays so it is refetched.
            case (r_state)
                S_REQ:   if (w_hs) w_state_nxt = S_WAIT;
                S_WAIT:  if (imem_rsp_valid) w_state_nxt = S_REQ;
                S_HOLD:  w_state_nxt = S_REQ;
                S_DROP:  if (imem_rsp_valid) w_state_nxt = S_REQ;
                default: w_state_nxt = S_REQ;
            endcase
        end else begin
            w_hold = stall_d;
            case (r_state)
                S_REQ:   if (w_hs) w_state_nxt = S_WAIT;
                S_WAIT: begin
                    if (imem_rsp_valid) begin
                        if (stall_d) begin
                            w_buf_nxt   = imem_rsp_data;
                            w_state_nxt = S_HOLD;
                        end else begin
                            w_load      = 1'b1;
                            w_state_nxt = S_REQ;
                        end
                    end
                end
                S_HOLD: begin
                    if (!stall_d) begin
                        w_load       = 1'b1;
                        w_load_instr = r_buf;
                        w_state_nxt  = S_REQ;
                    end
                end
                S_DROP:  if (imem_rsp_valid) w_state_nxt = S_REQ;
                default: w_state_nxt = S_REQ;
            endcase
            if (w_load) w_pc_f_nxt = w_pc_plus4_f;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_REQ;
            r_pc_f       <= RESET_VECTOR;
            r_buf        <= '0;
            r_instr_d    <= NOP;
            r_pc_d       <= '0;
            r_pc_plus4_d <= '0;
            r_valid_d    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc_f  <= w_pc_f_nxt;
            r_buf   <= w_buf_nxt;
            if (w_load) begin
                r_instr_d    <= w_load_instr;
                r_pc_d       <= r_pc_f;
                r_pc_plus4_d <= w_pc_plus4_f;
                r_valid_d    <= 1'b1;
            end else if (!w_hold) begin
                r_instr_d    <= NOP;
                r_pc_d       <= '0;
                r_pc_plus4_d <= '0;
                r_valid_d    <= 1'b0;
            end
        end
    end

    assign instr_d    = r_instr_d;
    assign pc_d       = r_pc_d;
    assign pc_plus4_d = r_pc_plus4_d;
    assign valid_d    = r_valid_d;
endmodule
